// File: rtl/multi_cycle_control.sv
// Main control FSM for the multi-cycle MIPS CPU: sequences fetch/decode/execute/mem/write-back
// and drives every datapath select and strobe from the registered state.
module multi_cycle_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       BranchNe,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_LW   = 6'h23, OP_SW   = 6'h2B,
                           OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_J    = 6'h02,
                           OP_ADDI  = 6'h08, OP_SLTI = 6'h0A, OP_ORI  = 6'h0D,
                           OP_XORI  = 6'h0E, OP_LUI  = 6'h0F;

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,  S_MEMWB = 4'd5,  S_MEMWR  = 4'd6,  S_EXEC   = 4'd7,
        S_RWB    = 4'd8,  S_BRANCH = 4'd9, S_JUMP   = 4'd10, S_IEXEC  = 4'd11,
        S_IWB    = 4'd12
    } state_t;

    state_t cur;
    assign state = cur;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= S_RESET;
        end else begin
            case (cur)
                S_RESET:  cur <= S_FETCH;
                S_FETCH:  if (mem_ready) cur <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW:     cur <= S_MEMADR;
                        OP_RTYPE:         cur <= S_EXEC;
                        OP_BEQ, OP_BNE:   cur <= S_BRANCH;
                        OP_J:             cur <= S_JUMP;
                        OP_ADDI, OP_SLTI, OP_ORI, OP_XORI, OP_LUI: cur <= S_IEXEC;
                        default:          cur <= S_FETCH;
                    endcase
                end
                S_MEMADR: cur <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (mem_ready) cur <= S_MEMWB;
                S_MEMWR:  if (mem_ready) cur <= S_FETCH;
                S_EXEC:   cur <= S_RWB;
                S_IEXEC:  cur <= S_IWB;
                S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_IWB: cur <= S_FETCH;
                default:  cur <= S_RESET;
            endcase
        end
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNe    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        case (cur)
            S_FETCH: begin
                // IR and PC load only on the completing cycle so a stalled fetch pulses once
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J,
                    OP_ADDI, OP_SLTI, OP_ORI, OP_XORI, OP_LUI: illegal_op = 1'b0;
                    default: illegal_op = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_RWB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                BranchNe    = (opcode == OP_BNE);
                instr_done  = 1'b1;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
            end
            S_IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = (opcode == OP_ADDI) ? 2'b00 : 2'b11;
            end
            S_IWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed-vector bench for multi_cycle_control: walks each instruction class cycle by cycle
// and compares state plus the packed control word against hand-written expectations.
module tb_multi_cycle_control;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic       mem_ready = 1'b1;
    logic       PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, instr_done, illegal_op;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    multi_cycle_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
    );

    // {PCWrite,PCWriteCond,BranchNe,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,
    //  ALUSrcA,ALUSrcB[1:0],ALUOp[1:0],PCSource[1:0],instr_done,illegal_op}
    logic [18:0] ctrl;
    assign ctrl = {PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
                   MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
                   instr_done, illegal_op};

    localparam logic [18:0] E_ZERO    = 19'b0_0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [18:0] E_FETCH   = 19'b1_0_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
    localparam logic [18:0] E_FETCH_W = 19'b0_0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
    localparam logic [18:0] E_DECODE  = 19'b0_0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
    localparam logic [18:0] E_DEC_ILL = 19'b0_0_0_0_0_0_0_0_0_0_0_11_00_00_0_1;
    localparam logic [18:0] E_MEMADR  = 19'b0_0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [18:0] E_MEMRD   = 19'b0_0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [18:0] E_MEMWB   = 19'b0_0_0_0_0_0_0_1_0_1_0_00_00_00_1_0;
    localparam logic [18:0] E_MEMWR_W = 19'b0_0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
    localparam logic [18:0] E_MEMWR   = 19'b0_0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
    localparam logic [18:0] E_EXEC    = 19'b0_0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
    localparam logic [18:0] E_RWB     = 19'b0_0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
    localparam logic [18:0] E_BEQ     = 19'b0_1_0_0_0_0_0_0_0_0_1_00_01_01_1_0;
    localparam logic [18:0] E_BNE     = 19'b0_1_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
    localparam logic [18:0] E_JUMP    = 19'b1_0_0_0_0_0_0_0_0_0_0_00_00_10_1_0;
    localparam logic [18:0] E_IEX_ADD = 19'b0_0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [18:0] E_IEX_IMM = 19'b0_0_0_0_0_0_0_0_0_0_1_10_11_00_0_0;
    localparam logic [18:0] E_IWB     = 19'b0_0_0_0_0_0_0_0_0_1_0_00_00_00_1_0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply mem_ready for one cycle, check the settled outputs, then advance past the edge.
    task automatic cyc(input string tag, input logic mr, input logic [3:0] es,
                       input logic [18:0] ec);
        mem_ready = mr;
        #1;
        chk({tag, ".state"}, {28'd0, state}, {28'd0, es});
        chk({tag, ".ctrl"}, {13'd0, ctrl}, {13'd0, ec});
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        // reset held for three edges
        cyc("rst0", 1'b1, 4'd0, E_ZERO);
        cyc("rst1", 1'b1, 4'd0, E_ZERO);
        cyc("rst2", 1'b1, 4'd0, E_ZERO);
        rst = 1'b0;
        cyc("rel", 1'b1, 4'd0, E_ZERO);

        opcode = 6'h00;
        cyc("r.fetch", 1'b1, 4'd1, E_FETCH);
        cyc("r.dec",   1'b1, 4'd2, E_DECODE);
        cyc("r.exec",  1'b1, 4'd7, E_EXEC);
        cyc("r.rwb",   1'b1, 4'd8, E_RWB);

        opcode = 6'h23;
        cyc("lw.fetch", 1'b1, 4'd1, E_FETCH);
        cyc("lw.dec",   1'b1, 4'd2, E_DECODE);
        cyc("lw.adr",   1'b1, 4'd3, E_MEMADR);
        cyc("lw.rd0",   1'b0, 4'd4, E_MEMRD);
        cyc("lw.rd1",   1'b0, 4'd4, E_MEMRD);
        cyc("lw.rd2",   1'b1, 4'd4, E_MEMRD);
        cyc("lw.wb",    1'b1, 4'd5, E_MEMWB);

        opcode = 6'h04;
        cyc("beq.fetch", 1'b1, 4'd1, E_FETCH);
        cyc("beq.dec",   1'b1, 4'd2, E_DECODE);
        cyc("beq.br",    1'b1, 4'd9, E_BEQ);
        opcode = 6'h05;
        cyc("bne.fetch", 1'b1, 4'd1, E_FETCH);
        cyc("bne.dec",   1'b1, 4'd2, E_DECODE);
        cyc("bne.br",    1'b1, 4'd9, E_BNE);

        opcode = 6'h02;
        cyc("j.fetch", 1'b1, 4'd1, E_FETCH);
        cyc("j.dec",   1'b1, 4'd2, E_DECODE);
        cyc("j.jump",  1'b1, 4'd10, E_JUMP);

        opcode = 6'h08;
        cyc("addi.fetch", 1'b1, 4'd1, E_FETCH);
        cyc("addi.dec",   1'b1, 4'd2, E_DECODE);
        cyc("addi.iex",   1'b1, 4'd11, E_IEX_ADD);
        cyc("addi.iwb",   1'b1, 4'd12, E_IWB);
        opcode = 6'h0F;
        cyc("lui.fetch", 1'b1, 4'd1, E_FETCH);
        cyc("lui.dec",   1'b1, 4'd2, E_DECODE);
        cyc("lui.iex",   1'b1, 4'd11, E_IEX_IMM);
        cyc("lui.iwb",   1'b1, 4'd12, E_IWB);

        // sw with a stalled fetch and a stalled write
        opcode = 6'h2B;
        cyc("sw.fetchw", 1'b0, 4'd1, E_FETCH_W);
        cyc("sw.fetch",  1'b1, 4'd1, E_FETCH);
        cyc("sw.dec",    1'b1, 4'd2, E_DECODE);
        cyc("sw.adr",    1'b1, 4'd3, E_MEMADR);
        cyc("sw.wrw",    1'b0, 4'd6, E_MEMWR_W);
        cyc("sw.wr",     1'b1, 4'd6, E_MEMWR);

        opcode = 6'h3F;
        cyc("ill.fetch", 1'b1, 4'd1, E_FETCH);
        cyc("ill.dec",   1'b1, 4'd2, E_DEC_ILL);

        // lw interrupted by reset in MEMRD
        opcode = 6'h23;
        cyc("lwr.fetch", 1'b1, 4'd1, E_FETCH);
        cyc("lwr.dec",   1'b1, 4'd2, E_DECODE);
        cyc("lwr.adr",   1'b1, 4'd3, E_MEMADR);
        rst = 1'b1;
        cyc("lwr.rd",    1'b0, 4'd4, E_MEMRD);
        cyc("lwr.rst0",  1'b1, 4'd0, E_ZERO);
        rst = 1'b0;
        cyc("lwr.rst1",  1'b1, 4'd0, E_ZERO);
        cyc("lwr.fetch2", 1'b1, 4'd1, E_FETCH);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/multi_cycle_control.md
# multi_cycle_control

Main control FSM for the multi-cycle MIPS CPU. It sequences one instruction at a time through fetch, decode, execute, memory and write-back. From the instruction opcode it drives every datapath select and write strobe, including the 2-bit `ALUOp` consumed by the ALU-function decoder. Memory accesses use a `mem_ready` handshake so the same FSM works with single-cycle or multi-cycle memory.

## Interface
Parameters: none. The opcode values below are fixed.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `opcode` in 6: IR[31:26]. Stable from DECODE until the next FETCH.
- `mem_ready` in 1: memory completes the current access this cycle.
- `PCWrite` out 1: unconditional PC load.
- `PCWriteCond` out 1: conditional PC load. The PC loads when ALU zero XOR `BranchNe` is 1.
- `BranchNe` out 1: 1 = bne sense.
- `IorD` out 1: memory address source. 0 = PC, 1 = ALUOut.
- `MemRead` out 1: memory read request.
- `MemWrite` out 1: memory write request.
- `IRWrite` out 1: instruction register load.
- `MemtoReg` out 1: register write data. 0 = ALUOut, 1 = MDR.
- `RegDst` out 1: destination register. 0 = rt, 1 = rd.
- `RegWrite` out 1: register file write.
- `ALUSrcA` out 1: ALU A input. 0 = PC, 1 = A.
- `ALUSrcB` out 2: ALU B input. 00 = B, 01 = 4, 10 = ext imm, 11 = ext imm<<2.
- `ALUOp` out 2: 00 add, 01 sub, 10 R-type (funct decode), 11 immediate-op decode.
- `PCSource` out 2: PC source. 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `instr_done` out 1: one-cycle pulse in the final cycle of each instruction.
- `illegal_op` out 1: one-cycle pulse in DECODE when the opcode is unsupported.
- `state` out 4: current state encoding, for debug.

## Operation
Opcodes:
- R-type = 0x00
- lw = 0x23
- sw = 0x2B
- beq = 0x04
- bne = 0x05
- j = 0x02
- addi = 0x08
- slti = 0x0A
- ori = 0x0D
- xori = 0x0E
- lui = 0x0F

States and encodings: RESET=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, RWB=8, BRANCH=9, JUMP=10, IEXEC=11, IWB=12. Encodings 13–15 are unused and go to RESET on the next edge.

Outputs per state. Every output not listed is 0.
- **RESET**
  - Outputs: all 0.
  - Next: FETCH.
- **FETCH**
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=`mem_ready`.
  - Next: stays in FETCH while `mem_ready`=0, then DECODE.
- **DECODE**
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00. This computes the branch target into ALUOut.
  - Next by opcode: lw/sw → MEMADR; R-type → EXEC; beq/bne → BRANCH; j → JUMP; addi/slti/ori/xori/lui → IEXEC.
  - Any other opcode → FETCH with `illegal_op`=1.
- **MEMADR**
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Next: lw → MEMRD, sw → MEMWR.
- **MEMRD**
  - Outputs: MemRead=1, IorD=1.
  - Next: waits for `mem_ready`, then MEMWB.
- **MEMWB**
  - Outputs: RegWrite=1, MemtoReg=1, RegDst=0, `instr_done`=1.
  - Next: FETCH.
- **MEMWR**
  - Outputs: MemWrite=1, IorD=1, `instr_done`=`mem_ready`.
  - Next: waits for `mem_ready`, then FETCH.
- **EXEC**
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - Next: RWB.
- **RWB**
  - Outputs: RegWrite=1, RegDst=1, MemtoReg=0, `instr_done`=1.
  - Next: FETCH.
- **BRANCH**
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, BranchNe=(opcode==0x05), `instr_done`=1.
  - Next: FETCH.
- **JUMP**
  - Outputs: PCWrite=1, PCSource=10, `instr_done`=1.
  - Next: FETCH.
- **IEXEC**
  - Outputs: ALUSrcA=1, ALUSrcB=10. ALUOp=00 for addi; ALUOp=11 for slti/ori/xori/lui.
  - Next: IWB.
- **IWB**
  - Outputs: RegWrite=1, RegDst=0, MemtoReg=0, `instr_done`=1.
  - Next: FETCH.

Immediate extension (sign or zero) is handled outside this block.

## Timing
- `state` is registered. Outputs are combinational from `state`, `opcode` and `mem_ready`.
- Reset:
  - `rst`=1 at a rising edge forces `state`=RESET.
  - In RESET, every output is 0 and `state`=0.
  - The first FETCH is the cycle after the cycle in which `rst` is sampled low.
- Instruction latencies with `mem_ready` held at 1, counting FETCH through the `instr_done` cycle:
  - R-type: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq/bne: 3 cycles.
  - j: 3 cycles.
  - Immediate ops: 4 cycles.
- Each cycle of `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle. All other outputs hold steady during the wait.
- IRWrite and PCWrite in FETCH are asserted only in the cycle where `mem_ready`=1. They pulse exactly once per fetch.
- Reset mid-instruction: in the cycle `rst` is first high, strobes still follow the current state; from the next edge the FSM is in RESET. Memory and register file resets are the system's responsibility.
- `illegal_op` and `instr_done` are never high in the same cycle.
- Opcode decoding in BRANCH and IEXEC reads `opcode` live. IR stability is guaranteed because IRWrite is asserted only in FETCH.

## Test plan
- **Reset**
  - Stimulus: hold `rst`=1 for 3 cycles with `mem_ready`=1.
  - Response: `state`=0 and every output 0 during reset; `state`=1 one cycle after release, with MemRead=1 and IRWrite=PCWrite=1.
- **R-type**
  - Stimulus: opcode 0x00, `mem_ready`=1.
  - Response: state sequence 1,2,7,8,1. ALUOp=10 in EXEC; RegWrite=RegDst=1 and `instr_done`=1 in RWB.
- **lw with memory wait**
  - Stimulus: opcode 0x23, `mem_ready` low for 2 cycles in MEMRD.
  - Response: sequence 1,2,3,4,4,4,5,1. MemRead=IorD=1 held through all three MEMRD cycles; MemtoReg=RegWrite=1 in MEMWB.
- **Branches**
  - Stimulus: opcode 0x04, then opcode 0x05.
  - Response: both give 1,2,9. In BRANCH: ALUOp=01, PCWriteCond=1, PCSource=01; BranchNe=0 for 0x04 and 1 for 0x05.
- **Immediate ops**
  - Stimulus: opcode 0x08, then 0x0F, then 0x2B with `mem_ready`=0 for 1 cycle in FETCH.
  - Response: addi gives ALUOp=00 in IEXEC. lui gives ALUOp=11. sw gives sequence 1,1,2,3,6,1, with IRWrite high only in the second FETCH cycle and MemWrite=1 in MEMWR.
- **Illegal opcode, then reset mid-instruction**
  - Stimulus: opcode 0x3F; then assert `rst` during MEMRD of a lw.
  - Response: `illegal_op`=1 for one cycle in DECODE, then FETCH. The FSM reaches `state`=0 at the edge after `rst` is sampled high, with no further RegWrite.
